// File: rtl/dcache_dm.sv
// Direct-mapped write-back/write-allocate data cache, one word per line; optional hit counter via DCACHE_HITCOUNT_EN.
// Latency: hits complete combinationally in the same cycle; misses take 2 cycles (clean) or 3 (dirty) plus memory wait.
// Backpressure: the datapath holds its request until dhit; memory stalls the FSM for as long as mem_dwait is high.
module dcache_dm #(
   parameter int          SETS        = 16,
   parameter logic [31:0] HITCNT_ADDR = 32'h0000_3100
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        dmemREN,
   input  logic        dmemWEN,
   input  logic [31:0] dmemaddr,
   input  logic [31:0] dmemstore,
   input  logic        halt,
   output logic        dhit,
   output logic [31:0] dmemload,
   output logic        flushed,
   output logic        mem_dREN,
   output logic        mem_dWEN,
   output logic [31:0] mem_daddr,
   output logic [31:0] mem_dstore,
   input  logic        mem_dwait,
   input  logic [31:0] mem_dload
);

   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = 30 - IDX_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SETS - 1);

   typedef enum logic [2:0] {
      IDLE,
      WB,
      FETCH,
      FLUSH,
`ifdef DCACHE_HITCOUNT_EN
      CNT,
`endif
      DONE
   } state_t;

   state_t state, next_state;

   logic             valid_q [SETS];
   logic             dirty_q [SETS];
   logic [TAG_W-1:0] tag_q   [SETS];
   logic [31:0]      data_q  [SETS];

   logic [IDX_W-1:0] idx;
   logic [TAG_W-1:0] tag;
   logic [IDX_W-1:0] fidx;
   logic             req;
   logic             hit;
   logic             flush_dirty;
   logic             flush_step;
   logic             unused_addr_lsb;

`ifdef DCACHE_HITCOUNT_EN
   logic [31:0] hit_cnt;
`endif

   assign idx             = dmemaddr[IDX_W+1:2];
   assign tag             = dmemaddr[31:IDX_W+2];
   assign req             = dmemREN | dmemWEN;
   assign hit             = req & valid_q[idx] & (tag_q[idx] == tag);
   assign flush_dirty     = valid_q[fidx] & dirty_q[fidx];
   assign unused_addr_lsb = ^dmemaddr[1:0];

   // State register; reset drops every memory request asynchronously.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state <= IDLE;
      else       state <= next_state;
   end

   // Next-state logic and all outputs, decoded from the current state.
   always_comb begin
      next_state = state;
      dhit       = 1'b0;
      dmemload   = '0;
      flushed    = 1'b0;
      mem_dREN   = 1'b0;
      mem_dWEN   = 1'b0;
      mem_daddr  = '0;
      mem_dstore = '0;
      flush_step = 1'b0;
      case (state)
         IDLE: begin
            dhit     = hit;
            dmemload = hit ? data_q[idx] : '0;
            if (req && !hit)
               next_state = (valid_q[idx] && dirty_q[idx]) ? WB : FETCH;
            else if (halt)
               next_state = FLUSH;
         end
         WB: begin
            mem_dWEN   = 1'b1;
            mem_daddr  = {tag_q[idx], idx, 2'b00};
            mem_dstore = data_q[idx];
            if (!mem_dwait) next_state = req ? FETCH : IDLE;
         end
         FETCH: begin
            mem_dREN  = 1'b1;
            mem_daddr = {dmemaddr[31:2], 2'b00};
            if (!mem_dwait) next_state = IDLE;
         end
         FLUSH: begin
            if (flush_dirty) begin
               mem_dWEN   = 1'b1;
               mem_daddr  = {tag_q[fidx], fidx, 2'b00};
               mem_dstore = data_q[fidx];
               flush_step = !mem_dwait;
            end else begin
               flush_step = 1'b1;
            end
            if (flush_step && fidx == LAST_IDX) begin
`ifdef DCACHE_HITCOUNT_EN
               next_state = CNT;
`else
               next_state = DONE;
`endif
            end
         end
`ifdef DCACHE_HITCOUNT_EN
         CNT: begin
            mem_dWEN   = 1'b1;
            mem_daddr  = HITCNT_ADDR;
            mem_dstore = hit_cnt;
            if (!mem_dwait) next_state = DONE;
         end
`endif
         DONE: begin
            flushed = 1'b1;
         end
         default: next_state = IDLE;
      endcase
   end

   // Line arrays: write hits, write-back/flush dirty clears, and fill on fetch completion.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < SETS; i++) begin
            valid_q[i] <= 1'b0;
            dirty_q[i] <= 1'b0;
            tag_q[i]   <= '0;
            data_q[i]  <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (hit && dmemWEN) begin
                  data_q[idx]  <= dmemstore;
                  dirty_q[idx] <= 1'b1;
               end
            end
            WB: begin
               if (!mem_dwait) dirty_q[idx] <= 1'b0;
            end
            FETCH: begin
               if (!mem_dwait) begin
                  valid_q[idx] <= 1'b1;
                  dirty_q[idx] <= 1'b0;
                  tag_q[idx]   <= tag;
                  data_q[idx]  <= mem_dload;
               end
            end
            FLUSH: begin
               if (flush_dirty && !mem_dwait) dirty_q[fidx] <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Flush walk pointer, advanced once per line visited.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)                          fidx <= '0;
      else if (state == FLUSH && flush_step) fidx <= fidx + 1'b1;
   end

`ifdef DCACHE_HITCOUNT_EN
   // Saturating count of completed datapath hits, reported to memory after the flush.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)                                          hit_cnt <= '0;
      else if (state == IDLE && hit && hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
   end
`endif

endmodule

// File: tb/tb_dcache_dm.sv
// Directed bench for dcache_dm with a word-addressed memory model and scoreboard queues.
// Read data and write-back traffic are predicted when stimulus is driven, compared when the cache responds.
// Memory stalls are injected per request; all waits are bounded.
module tb_dcache_dm;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        dmemREN, dmemWEN, halt;
   logic [31:0] dmemaddr, dmemstore, dmemload;
   logic        dhit, flushed;
   logic        mem_dREN, mem_dWEN, mem_dwait;
   logic [31:0] mem_daddr, mem_dstore, mem_dload;

   int n_cmp = 0;
   int n_err = 0;
   int n_rd  = 0;
   int n_wr  = 0;
   int n_hits = 0;

   logic [31:0] mem_q [0:4095];
   bit          mem_w [0:4095];
   logic [63:0] exp_wr_q [$];
   logic [63:0] obs_wr_q [$];
   logic [31:0] exp_rd_q [$];

   dcache_dm dut (
      .CLK(CLK), .nRST(nRST),
      .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
      .halt(halt), .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
      .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_daddr(mem_daddr), .mem_dstore(mem_dstore),
      .mem_dwait(mem_dwait), .mem_dload(mem_dload)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] init_word(input logic [31:0] a);
      case (a)
         32'h0000_0040: return 32'hDEAD_BEEF;
         32'h0000_0440: return 32'hCAFE_0440;
         32'h0000_0014: return 32'h0000_0055;
         default:       return a ^ 32'h5A5A_0000;
      endcase
   endfunction

   assign mem_dload = mem_w[mem_daddr[13:2]] ? mem_q[mem_daddr[13:2]]
                                             : init_word({mem_daddr[31:2], 2'b00});

   // Memory model: a transfer completes on the edge following a negedge with request high and no wait.
   always @(negedge CLK) begin
      if (nRST && !mem_dwait) begin
         if (mem_dWEN) begin
            n_wr++;
            obs_wr_q.push_back({mem_daddr, mem_dstore});
            mem_q[mem_daddr[13:2]] = mem_dstore;
            mem_w[mem_daddr[13:2]] = 1'b1;
         end else if (mem_dREN) begin
            n_rd++;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_writes(input string tag);
      logic [63:0] e, o;
      check({tag, "_wr_count"}, 32'(obs_wr_q.size()), 32'(exp_wr_q.size()));
      while (obs_wr_q.size() > 0 && exp_wr_q.size() > 0) begin
         e = exp_wr_q.pop_front();
         o = obs_wr_q.pop_front();
         check({tag, "_wr_addr"}, o[63:32], e[63:32]);
         check({tag, "_wr_data"}, o[31:0], e[31:0]);
      end
      obs_wr_q.delete();
      exp_wr_q.delete();
   endtask

   // Drive one request at posedge+2, wait (bounded) for dhit, check latency and read data.
   task automatic do_req(input logic ren, input logic wen, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] exp_load,
                         input int exp_lat, input int stall_n, input string tag);
      int lat = 0;
      int stall = stall_n;
      bit got = 1'b0;
      dmemREN = ren; dmemWEN = wen; dmemaddr = addr; dmemstore = data;
      mem_dwait = (stall > 0);
      if (ren && !wen) exp_rd_q.push_back(exp_load);
      for (int c = 0; c < 100; c++) begin
         @(negedge CLK);
         if (dhit) begin got = 1'b1; break; end
         if ((mem_dREN || mem_dWEN) && stall > 0) stall--;
         @(posedge CLK); #2;
         mem_dwait = (stall > 0);
         lat++;
      end
      check({tag, "_dhit"}, 32'(got), 32'd1);
      if (got) begin
         n_hits++;
         check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
         if (ren && !wen) check({tag, "_load"}, dmemload, exp_rd_q.pop_front());
      end else begin
         exp_rd_q.delete();
      end
      @(posedge CLK); #2;
      dmemREN = 1'b0; dmemWEN = 1'b0; mem_dwait = 1'b0;
   endtask

   initial begin
      int base, cyc;
      bit done;
      nRST = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; dmemaddr = '0; dmemstore = '0;
      halt = 1'b0; mem_dwait = 1'b0;

      @(negedge CLK);
      check("rst_dhit",     32'(dhit),     32'd0);
      check("rst_flushed",  32'(flushed),  32'd0);
      check("rst_mem_dREN", 32'(mem_dREN), 32'd0);
      check("rst_mem_dWEN", 32'(mem_dWEN), 32'd0);
      check("rst_daddr",    mem_daddr,     32'd0);
      check("rst_dstore",   mem_dstore,    32'd0);
      check("rst_dmemload", dmemload,      32'd0);
      @(posedge CLK); #2;
      nRST = 1'b1;

      base = n_rd;
      do_req(1'b1, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 2, 0, "cold_rd");
      check("cold_rd_fetches", 32'(n_rd - base), 32'd1);
      do_req(1'b1, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 0, 0, "rd_hit");

      base = n_rd + n_wr;
      do_req(1'b0, 1'b1, 32'h40, 32'h11, 32'h0, 0, 0, "wr_hit");
      check("wr_hit_no_traffic", 32'(n_rd + n_wr), 32'(base));
      do_req(1'b1, 1'b0, 32'h40, 32'h0, 32'h11, 0, 0, "rd_after_wr");

      exp_wr_q.push_back({32'h40, 32'h11});
      do_req(1'b1, 1'b0, 32'h440, 32'h0, 32'hCAFE_0440, 3, 0, "evict_rd");
      check_writes("evict");

      do_req(1'b0, 1'b1, 32'h440, 32'h22, 32'h0, 0, 0, "wr_440");

      base = n_rd;
      do_req(1'b1, 1'b0, 32'h14, 32'h0, 32'h55, 7, 5, "slow_fetch");
      check("slow_fetch_completions", 32'(n_rd - base), 32'd1);

      do_req(1'b0, 1'b1, 32'h14, 32'h66, 32'h0, 0, 0, "wr_14");
      do_req(1'b1, 1'b1, 32'h14, 32'h77, 32'h0, 0, 0, "ren_wen_is_wr");

      exp_wr_q.push_back({32'h440, 32'h22});
      exp_wr_q.push_back({32'h14, 32'h77});
`ifdef DCACHE_HITCOUNT_EN
      exp_wr_q.push_back({32'h3100, 32'(n_hits)});
`endif
      halt = 1'b1;
      cyc = 0; done = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge CLK);
         if (flushed) begin done = 1'b1; break; end
         @(posedge CLK); #2;
         cyc++;
      end
      check("flush_done", 32'(done), 32'd1);
`ifdef DCACHE_HITCOUNT_EN
      check("flush_cycles", 32'(cyc), 32'd18);
`else
      check("flush_cycles", 32'(cyc), 32'd17);
`endif
      check_writes("flush");

      @(posedge CLK); #2;
      halt = 1'b0; dmemREN = 1'b1; dmemaddr = 32'h440;
      @(negedge CLK);
      check("done_dhit",     32'(dhit),     32'd0);
      check("done_mem_dREN", 32'(mem_dREN), 32'd0);
      @(posedge CLK); #2;
      dmemREN = 1'b0;
      repeat (3) @(posedge CLK);
      #2;
      check("flushed_sticky", 32'(flushed), 32'd1);

      nRST = 1'b0;
      #1;
      check("rst_clears_flushed", 32'(flushed), 32'd0);
      @(posedge CLK); #2;
      nRST = 1'b1;

      do_req(1'b0, 1'b1, 32'h40, 32'h99, 32'h0, 2, 0, "wr_miss");
      mem_dwait = 1'b1; halt = 1'b1;
      repeat (2) begin @(posedge CLK); #2; end
      @(negedge CLK);
      check("flush_stalled_wen",  32'(mem_dWEN), 32'd1);
      check("flush_stalled_addr", mem_daddr,     32'h40);
      check("flush_stalled_data", mem_dstore,    32'h99);
      #1;
      nRST = 1'b0;
      #1;
      check("midflush_rst_wen",     32'(mem_dWEN), 32'd0);
      check("midflush_rst_ren",     32'(mem_dREN), 32'd0);
      check("midflush_rst_daddr",   mem_daddr,     32'd0);
      check("midflush_rst_flushed", 32'(flushed),  32'd0);
      halt = 1'b0; mem_dwait = 1'b0;
      @(posedge CLK); #2;
      nRST = 1'b1;
      do_req(1'b1, 1'b0, 32'h40, 32'h0, 32'h11, 2, 0, "post_rst_rd");
      check_writes("post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
